// File: rtl/rr_slice_arbiter_pkg.sv
// rr_slice_arbiter_pkg: shared state encoding and width helper for the round-robin arbiter family.
package rr_slice_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_slice_arbiter_if.sv
// rr_slice_arbiter_if: request/slice/grant bundle between requesters and the arbiter.
interface rr_slice_arbiter_if #(
    parameter int N       = 4,
    parameter int SLICE_W = 4
);
    import rr_slice_arbiter_pkg::*;

    localparam int IDW = clog2(N);

    logic [N-1:0]       req;
    logic [SLICE_W-1:0] slice_len;
    logic [N-1:0]       gnt;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_valid;
    logic               slice_last;

    modport master (
        output req, slice_len,
        input  gnt, gnt_id, gnt_valid, slice_last
    );

    modport slave (
        input  req, slice_len,
        output gnt, gnt_id, gnt_valid, slice_last
    );

endinterface

// File: rtl/rr_slice_arbiter_pick.sv
// rr_pick: combinational rotating-priority search, first set req bit at or after ptr, wrapping.
module rr_pick
    import rr_slice_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   below_ptr;
    logic [2*N-1:0] dbl;

    // Lower copy keeps only bits at/after ptr; upper copy supplies the wrapped-around bits.
    assign below_ptr = ({{(N-1){1'b0}}, 1'b1} << ptr) - {{(N-1){1'b0}}, 1'b1};
    assign dbl       = {req, req & ~below_ptr};

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx   = IDW'(i % N);
            end
        end
    end

endmodule

// File: rtl/rr_slice_arbiter.sv
// rr_slice_arbiter: N-way round-robin arbiter granting fixed time slices with early release.
module rr_slice_arbiter
    import rr_slice_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int SLICE_W = 4
) (
    input logic            clk,
    input logic            rst,
    rr_slice_arbiter_if.slave bus
);

    localparam int IDW = clog2(N);

    state_t             state, state_n;
    logic [IDW-1:0]     owner, owner_n, last_owner, last_n, ptr, idx;
    logic [SLICE_W-1:0] cnt, cnt_n, start_cnt;
    logic               found, hold, valid;

    assign ptr       = (last_owner == IDW'(N-1)) ? '0 : last_owner + 1'b1;
    assign start_cnt = (bus.slice_len == '0) ? '0 : bus.slice_len - 1'b1;
    assign hold      = (state == ST_GRANT) && bus.req[owner] && (cnt != '0);

    // Release or expiry both search from owner+1; an unmasked req lets a sole owner re-win.
    rr_pick #(.N(N), .IDW(IDW)) pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        cnt_n   = cnt;
        if (hold) begin
            cnt_n = cnt - 1'b1;
        end else if (found) begin
            state_n = ST_GRANT;
            owner_n = idx;
            last_n  = idx;
            cnt_n   = start_cnt;
        end else begin
            state_n = ST_IDLE;
            owner_n = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= IDW'(N-1);
            cnt        <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            cnt        <= cnt_n;
        end
    end

    assign valid          = (state == ST_GRANT);
    assign bus.gnt_valid  = valid;
    assign bus.gnt        = valid ? ({{(N-1){1'b0}}, 1'b1} << owner) : '0;
    assign bus.gnt_id     = valid ? owner : '0;
    assign bus.slice_last = valid && (cnt == '0);

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// tb_rr_slice_arbiter: table-driven directed vectors plus a fairness sequence for rr_slice_arbiter.
module tb_rr_slice_arbiter;

    localparam int N       = 4;
    localparam int SLICE_W = 4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sl;
        logic [3:0] gnt;
        int         id;
        logic       valid;
        logic       last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    vec_t vecs[$];

    rr_slice_arbiter_if #(.N(N), .SLICE_W(SLICE_W)) bus ();

    rr_slice_arbiter #(.N(N), .SLICE_W(SLICE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] s,
                       input logic [3:0] g, input int i, input logic v, input logic l);
        vecs.push_back('{r, q, s, g, i, v, l});
    endtask

    initial begin
        int cnt_g[N];
        int prev;
        bus.req       = '0;
        bus.slice_len = '0;

        // reset state
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // single requester, slice 3, no gap
        add(0, 4'b0001, 3, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 3, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 3, 4'b0001, 0, 1, 1);
        add(0, 4'b0001, 3, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 3, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 3, 4'b0001, 0, 1, 1);
        // all requesting, slice 2
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 2, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 2, 4'b0001, 0, 1, 1);
        add(0, 4'b1111, 2, 4'b0010, 1, 1, 0);
        add(0, 4'b1111, 2, 4'b0010, 1, 1, 1);
        add(0, 4'b1111, 2, 4'b0100, 2, 1, 0);
        add(0, 4'b1111, 2, 4'b0100, 2, 1, 1);
        add(0, 4'b1111, 2, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 2, 4'b1000, 3, 1, 1);
        add(0, 4'b1111, 2, 4'b0001, 0, 1, 0);
        // early release, then release to idle
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0011, 5, 4'b0001, 0, 1, 0);
        add(0, 4'b0011, 5, 4'b0001, 0, 1, 0);
        add(0, 4'b0010, 5, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 5, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 5, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 5, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 5, 4'b0010, 1, 1, 1);
        add(0, 4'b0010, 5, 4'b0010, 1, 1, 0);
        add(0, 4'b0000, 5, 4'b0000, 0, 0, 0);
        // wrap and skip
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 1, 4'b0100, 2, 1, 1);
        add(0, 4'b1101, 1, 4'b1000, 3, 1, 1);
        add(0, 4'b1001, 1, 4'b0001, 0, 1, 1);
        add(0, 4'b1001, 1, 4'b1000, 3, 1, 1);
        // slice_len 0 and mid-slice change
        add(0, 4'b0011, 0, 4'b0001, 0, 1, 1);
        add(0, 4'b0011, 0, 4'b0010, 1, 1, 1);
        add(0, 4'b0011, 0, 4'b0001, 0, 1, 1);
        add(0, 4'b0011, 2, 4'b0010, 1, 1, 0);
        add(0, 4'b0011, 6, 4'b0010, 1, 1, 1);
        add(0, 4'b0011, 6, 4'b0001, 0, 1, 0);
        // new requests never preempt
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 4, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 4, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 4, 4'b0001, 0, 1, 1);
        add(0, 4'b1111, 4, 4'b0010, 1, 1, 0);
        // reset mid-grant
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 3, 4'b0100, 2, 1, 0);
        add(1, 4'b0100, 3, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 3, 4'b0001, 0, 1, 0);

        foreach (vecs[k]) begin
            rst           = vecs[k].rst;
            bus.req       = vecs[k].req;
            bus.slice_len = vecs[k].sl;
            step();
            check($sformatf("v%0d gnt", k), int'(bus.gnt), int'(vecs[k].gnt));
            check($sformatf("v%0d gnt_id", k), int'(bus.gnt_id), vecs[k].id);
            check($sformatf("v%0d gnt_valid", k), int'(bus.gnt_valid), int'(vecs[k].valid));
            check($sformatf("v%0d slice_last", k), int'(bus.slice_last), int'(vecs[k].last));
        end

        // fairness: 1-cycle slices, all requesting, strict rotation
        rst = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.slice_len = 4'd1;
        foreach (cnt_g[i]) cnt_g[i] = 0;
        prev = N - 1;
        for (int c = 0; c < 4 * N; c++) begin
            step();
            check($sformatf("fair c%0d gnt_id", c), int'(bus.gnt_id), (prev + 1) % N);
            check($sformatf("fair c%0d onehot", c), int'(bus.gnt), 1 << ((prev + 1) % N));
            prev = int'(bus.gnt_id);
            if (bus.gnt_valid) cnt_g[bus.gnt_id]++;
        end
        foreach (cnt_g[i]) check($sformatf("fair count%0d", i), cnt_g[i], 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
